uart_avmm_bridge: RTL

- Avalon-MM master driven by a UART byte stream: the initiator side for Avalon-MM register slaves such as the UART register block.
- Parses host frames from the UART receiver byte stream and issues single-word Avalon-MM writes and reads.
- Returns ACK, NAK or read-data bytes to the UART transmitter byte stream.
- Sits between a uart_rx_tx core (plus FIFOs) and a system Avalon-MM interconnect, giving a host PC register access.

---
 rtl/uart_avmm_bridge_if.sv | 34 +++
 rtl/uart_avmm_bridge.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/uart_avmm_bridge_if.sv
// Signal bundle between the bridge, the UART byte streams and the Avalon-MM interconnect.
// master is the bridge's view; slave is the surrounding system's view.
interface uart_avmm_bridge_if #(
  parameter int unsigned ADDR_W = 3
);
  logic [7:0]        rx_data_i;
  logic              rx_perr_i;
  logic              rx_valid_i;
  logic [7:0]        tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i;
  logic [ADDR_W-1:0] avmm_address_o;
  logic              avmm_write_o;
  logic              avmm_read_o;
  logic [31:0]       avmm_writedata_o;
  logic [3:0]        avmm_byteenable_o;
  logic              avmm_waitrequest_i;
  logic [31:0]       avmm_readdata_i;
  logic              avmm_readdatavalid_i;

  modport master (
    input  rx_data_i, rx_perr_i, rx_valid_i, tx_ready_i,
    input  avmm_waitrequest_i, avmm_readdata_i, avmm_readdatavalid_i,
    output tx_data_o, tx_valid_o,
    output avmm_address_o, avmm_write_o, avmm_read_o, avmm_writedata_o, avmm_byteenable_o
  );

  modport slave (
    output rx_data_i, rx_perr_i, rx_valid_i, tx_ready_i,
    output avmm_waitrequest_i, avmm_readdata_i, avmm_readdatavalid_i,
    input  tx_data_o, tx_valid_o,
    input  avmm_address_o, avmm_write_o, avmm_read_o, avmm_writedata_o, avmm_byteenable_o
  );
endinterface

// File: rtl/uart_avmm_bridge.sv
// UART-framed Avalon-MM master: parses write/read frames from the rx byte stream,
// performs one single-word bus access and answers with ACK, NAK or four read-data bytes.
module uart_avmm_bridge #(
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                reset_n,
  uart_avmm_bridge_if.master  bus
);

  localparam logic [7:0] SofWr = 8'hA5;
  localparam logic [7:0] SofRd = 8'h5A;
  localparam logic [7:0] Ack   = 8'h06;
  localparam logic [7:0] Nak   = 8'h15;

  localparam int unsigned ToW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StAddr, StData, StBusWr, StBusRd, StRdWait, StResp
  } state_e;

  state_e         state_q;
  logic           is_wr_q;
  logic [1:0]     byte_cnt_q;
  logic [ToW-1:0] to_cnt_q;
  logic [31:0]    resp_q;       // read-data bytes still to be sent, next byte in [7:0]
  logic [1:0]     resp_left_q;  // bytes remaining after the one on tx_data_o

  assign bus.avmm_byteenable_o = (bus.avmm_write_o || bus.avmm_read_o) ? 4'hF : 4'h0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q              <= StIdle;
      is_wr_q              <= 1'b0;
      byte_cnt_q           <= 2'd0;
      to_cnt_q             <= '0;
      resp_q               <= 32'h0;
      resp_left_q          <= 2'd0;
      bus.tx_data_o        <= 8'h00;
      bus.tx_valid_o       <= 1'b0;
      bus.avmm_address_o   <= '0;
      bus.avmm_write_o     <= 1'b0;
      bus.avmm_read_o      <= 1'b0;
      bus.avmm_writedata_o <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.rx_valid_i) begin
            to_cnt_q   <= '0;
            byte_cnt_q <= 2'd0;
            if (bus.rx_perr_i || !(bus.rx_data_i == SofWr || bus.rx_data_i == SofRd)) begin
              state_q        <= StResp;
              bus.tx_valid_o <= 1'b1;
              bus.tx_data_o  <= Nak;
              resp_left_q    <= 2'd0;
            end else begin
              is_wr_q <= (bus.rx_data_i == SofWr);
              state_q <= StAddr;
            end
          end
        end

        StAddr, StData: begin
          if (bus.rx_valid_i) begin
            to_cnt_q <= '0;
            if (bus.rx_perr_i) begin
              state_q        <= StResp;
              bus.tx_valid_o <= 1'b1;
              bus.tx_data_o  <= Nak;
              resp_left_q    <= 2'd0;
            end else if (state_q == StAddr) begin
              bus.avmm_address_o <= bus.rx_data_i[ADDR_W-1:0];
              byte_cnt_q         <= 2'd0;
              if (is_wr_q) begin
                state_q <= StData;
              end else begin
                state_q         <= StBusRd;
                bus.avmm_read_o <= 1'b1;
              end
            end else begin
              bus.avmm_writedata_o <= {bus.rx_data_i, bus.avmm_writedata_o[31:8]};
              byte_cnt_q           <= byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd3) begin
                state_q          <= StBusWr;
                bus.avmm_write_o <= 1'b1;
              end
            end
          end else if (to_cnt_q == ToLast) begin
            // Host went quiet mid-frame: drop it without answering.
            state_q  <= StIdle;
            to_cnt_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
          end
        end

        StBusWr: begin
          if (!bus.avmm_waitrequest_i) begin
            bus.avmm_write_o <= 1'b0;
            state_q          <= StResp;
            bus.tx_valid_o   <= 1'b1;
            bus.tx_data_o    <= Ack;
            resp_left_q      <= 2'd0;
          end
        end

        StBusRd: begin
          if (!bus.avmm_waitrequest_i) begin
            bus.avmm_read_o <= 1'b0;
            if (bus.avmm_readdatavalid_i) begin
              state_q        <= StResp;
              bus.tx_valid_o <= 1'b1;
              bus.tx_data_o  <= bus.avmm_readdata_i[7:0];
              resp_q         <= {8'h00, bus.avmm_readdata_i[31:8]};
              resp_left_q    <= 2'd3;
            end else begin
              state_q <= StRdWait;
            end
          end
        end

        StRdWait: begin
          if (bus.avmm_readdatavalid_i) begin
            state_q        <= StResp;
            bus.tx_valid_o <= 1'b1;
            bus.tx_data_o  <= bus.avmm_readdata_i[7:0];
            resp_q         <= {8'h00, bus.avmm_readdata_i[31:8]};
            resp_left_q    <= 2'd3;
          end
        end

        StResp: begin
          if (bus.tx_ready_i) begin
            if (resp_left_q == 2'd0) begin
              bus.tx_valid_o <= 1'b0;
              state_q        <= StIdle;
            end else begin
              bus.tx_data_o <= resp_q[7:0];
              resp_q        <= {8'h00, resp_q[31:8]};
              resp_left_q   <= resp_left_q - 2'd1;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
